// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU command issuer: opcodes, FSM states and launch timing.
package fpu_pkg;

  localparam logic [3:0] OP_IDLE = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_DIV  = 4'd4;
  localparam logic [3:0] OP_SIN  = 4'd5;
  localparam logic [3:0] OP_COS  = 4'd6;
  localparam logic [3:0] OP_LOG  = 4'd7;
  localparam logic [3:0] OP_EXP  = 4'd8;
  localparam logic [3:0] OP_SQR  = 4'd9;

  localparam int DEFAULT_MIN_WAIT = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SQR);
  endfunction

endpackage

// File: rtl/fpu_cmd_issuer.sv
// Host-side initiator: accepts one command, launches it on the FPU controller,
// waits for a trusted valid (or times out) and holds the result in a one-entry slot.
module fpu_cmd_issuer
  import fpu_pkg::*;
#(
  parameter int PRECISION_LEN = 64,
  parameter int TIMEOUT       = 64,
  parameter int MIN_WAIT      = DEFAULT_MIN_WAIT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_op,
  input  logic [PRECISION_LEN-1:0] cmd_a,
  input  logic [PRECISION_LEN-1:0] cmd_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [PRECISION_LEN-1:0] rsp_data,
  output logic [3:0]               rsp_op,
  output logic                     rsp_err,
  output logic                     rsp_timeout,
  output logic [PRECISION_LEN-1:0] fpu_a,
  output logic [PRECISION_LEN-1:0] fpu_b,
  output logic [3:0]               fpu_operation,
  output logic                     fpu_enable,
  input  logic [PRECISION_LEN-1:0] fpu_result,
  input  logic                     fpu_valid,
  input  logic                     fpu_busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] MIN_WAIT_C = CNT_W'(MIN_WAIT);
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);

  state_t           r_state;
  logic [3:0]       r_op;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_accept;

  assign cmd_ready = (r_state == S_IDLE) && !fpu_busy && !rsp_valid;
  assign w_accept  = cmd_valid && cmd_ready;

  // Issue FSM; r_wait_cnt counts cycles since the launch cycle, so it reads 0 during S_ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_op          <= OP_IDLE;
      r_wait_cnt    <= '0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_op        <= OP_IDLE;
      rsp_err       <= 1'b0;
      rsp_timeout   <= 1'b0;
      fpu_a         <= '0;
      fpu_b         <= '0;
      fpu_operation <= OP_IDLE;
      fpu_enable    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op <= cmd_op;
            if (is_legal_op(cmd_op)) begin
              r_state       <= S_ISSUE;
              r_wait_cnt    <= '0;
              fpu_operation <= cmd_op;
              fpu_enable    <= 1'b1;
              fpu_a         <= cmd_a;
              fpu_b         <= cmd_b;
            end else begin
              r_state   <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
              rsp_op    <= cmd_op;
              rsp_err   <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          fpu_enable <= 1'b0;
          r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          // Early valids are the controller's IDLE-path echo, not our result.
          if (fpu_valid && (r_wait_cnt >= MIN_WAIT_C)) begin
            r_state       <= S_RESP;
            rsp_valid     <= 1'b1;
            rsp_data      <= fpu_result;
            rsp_op        <= r_op;
            fpu_operation <= OP_IDLE;
          end else if (r_wait_cnt == TIMEOUT_C) begin
            r_state       <= S_RESP;
            rsp_valid     <= 1'b1;
            rsp_data      <= '0;
            rsp_op        <= r_op;
            rsp_timeout   <= 1'b1;
            fpu_operation <= OP_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state     <= S_IDLE;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fpu_cmd_issuer.md
Name: fpu_cmd_issuer

Overview:
Host-side initiator that drives the FPU controller's operand/opcode interface. It accepts commands through a valid/ready queue port, waits for the controller to be idle, and presents the opcode and operands. It then holds the opcode until the unit's valid arrives, captures the result into a one-entry response slot with backpressure, and times out hung operations. It sits between the system command bus and the FPU controller.

Parameters:
PRECISION_LEN, 64, operand/result width (IEEE-754 double).
TIMEOUT, 64, max cycles in WAIT before a forced timeout response (must be ≥ 34).
MIN_WAIT, 2, cycles after opcode launch before fpu_valid is trusted (controller opcode pipeline depth).

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-high reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  command accepted when valid&&ready.
cmd_op  in  4  opcode.
cmd_a  in  PRECISION_LEN  operand A.
cmd_b  in  PRECISION_LEN  operand B.
rsp_valid  out  1  response slot full.
rsp_ready  in  1  consumer takes response.
rsp_data  out  PRECISION_LEN  captured result.
rsp_op  out  4  opcode of this response.
rsp_err  out  1  illegal opcode, not issued.
rsp_timeout  out  1  FPU never signalled valid.
fpu_a  out  PRECISION_LEN  to controller a_in.
fpu_b  out  PRECISION_LEN  to controller b_in.
fpu_operation  out  4  to controller operation.
fpu_enable  out  1  one-cycle launch strobe.
fpu_result  in  PRECISION_LEN  from controller.
fpu_valid  in  1  from controller.
fpu_busy  in  1  from controller.

Behaviour:
- All outputs are registered except cmd_ready. On rst, all outputs are 0, fpu_operation=IDLE (0), state=S_IDLE, and counters are 0. Reset mid-operation aborts immediately, with no response produced.
- Opcodes: IDLE=0, ADD=1, SUB=2, MUL=3, DIV=4, SIN=5, COS=6, LOG=7, EXP=8, SQR=9. Codes 0 and 10..15 are illegal.
- cmd_ready = (state==S_IDLE) && !fpu_busy && !rsp_valid.
- S_IDLE: on accept (cycle T0), latch op/a/b.
  - Illegal op: go to S_RESP with rsp_data=0, rsp_err=1, no FPU activity.
  - Legal op: go to S_ISSUE.
- S_ISSUE (T1, one cycle): fpu_operation=op, fpu_enable=1, fpu_a/fpu_b=operands. wait_cnt is cleared. Go to S_WAIT.
- S_WAIT:
  - Outputs: fpu_enable=0; fpu_operation, fpu_a and fpu_b are held; wait_cnt increments every cycle.
  - fpu_valid is ignored while wait_cnt < MIN_WAIT, because the controller reports IDLE-path valid=1 until the opcode has propagated.
  - First fpu_valid with wait_cnt ≥ MIN_WAIT: register fpu_result into rsp_data and go to S_RESP. ADD/MUL therefore complete with rsp_valid at T1+MIN_WAIT+1 at the earliest.
  - wait_cnt == TIMEOUT: rsp_data=0, rsp_timeout=1, go to S_RESP.
  - fpu_valid and timeout in the same cycle: valid wins.
- S_RESP:
  - Outputs: rsp_valid=1, rsp_op=latched op, fpu_operation=IDLE, fpu_a/fpu_b hold their values.
  - On rsp_ready: clear rsp_valid, rsp_err and rsp_timeout, and go to S_IDLE.
  - rsp_data/rsp_op are stable while rsp_valid && !rsp_ready.
- The next command cannot be accepted in the same cycle as rsp_ready, giving a minimum 1-cycle bubble.
- fpu_busy is checked only for acceptance. It is ignored in S_ISSUE/S_WAIT because busy rises combinationally from the issuer's own opcode.
- wait_cnt width is $clog2(TIMEOUT+1) and saturates; it never wraps.

Decomposition:
- Shared package fpu_pkg holds:
  - opcode constants (IDLE..SQR) and an is_legal_op function;
  - the state enum S_IDLE/S_ISSUE/S_WAIT/S_RESP;
  - the default MIN_WAIT.
- No sub-module: the FSM, counter and response slot stay flat in one file.
- The bench uses a behavioural controller model with per-opcode programmable latency. That model also asserts valid=1 whenever operation is IDLE.

Test Plan:
1. MUL a=0x4000000000000000 (2.0), b=0x4008000000000000 (3.0), model latency 2, rsp_ready=1 -> fpu_enable pulses once at T1. rsp_valid=1 with rsp_data=0x4018000000000000 (6.0), rsp_op=3, err=timeout=0. cmd_ready returns 1 one cycle after the handshake.
2. DIV with latency 31 and rsp_ready held 0 for 10 cycles -> fpu_operation stays 4 until capture. rsp_valid/rsp_data stay stable for 10 cycles. cmd_ready=0 throughout, then 1 one cycle after rsp_ready.
3. cmd_op=12 -> no fpu_enable pulse. rsp_valid the cycle after acceptance with rsp_err=1 and rsp_data=0.
4. LOG with the model never asserting valid (non-IDLE), TIMEOUT=64 -> rsp_timeout=1 and rsp_data=0 exactly TIMEOUT+1 cycles after T1. fpu_operation returns to 0.
5. fpu_busy=1 while cmd_valid=1 for 5 cycles -> cmd_ready=0 and no issue. Acceptance occurs the cycle fpu_busy drops.
6. rst asserted asynchronously mid-S_WAIT of SQR -> all outputs 0 immediately, no rsp_valid. After release, an ADD (1.0+1.0 -> 0x4000000000000000) completes normally.
